aes_sbox_pipe: RTL

Parametrised, pipelined AES S-box engine: substitutes LANES bytes per transfer in forward (SubBytes) or inverse (InvSubBytes) direction, selected per transfer. It has a valid/ready handshake on both sides, a two-stage pipeline and full throughput of one word per cycle. It sits between the round-key/state datapath and the key-expansion logic, and replaces the fixed 32-bit combinational inverse-only substitution where registered timing and back-pressure are needed.

---
 rtl/aes_sbox_pkg.sv | 56 +++++
 rtl/aes_sbox_lane.sv | 24 ++
 rtl/aes_sbox_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/aes_sbox_pkg.sv
// Shared AES byte-substitution constants and lookup helpers.
//   AES_BYTE_W : width of one substituted byte
//   SBOX       : forward S-box table (SubBytes)
//   INV_SBOX   : inverse S-box table (InvSubBytes)
//   sbox_fwd() / sbox_inv() : single-byte lookups
package aes_sbox_pkg;

  localparam int unsigned AES_BYTE_W = 8;

  localparam logic [AES_BYTE_W-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [AES_BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [AES_BYTE_W-1:0] sbox_fwd(input logic [AES_BYTE_W-1:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [AES_BYTE_W-1:0] sbox_inv(input logic [AES_BYTE_W-1:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One-byte AES substitution, purely combinational.
//   i_byte   : byte to substitute
//   i_inv    : 1 = inverse S-box, 0 = forward S-box
//   o_byte_c : substituted byte
// Build option AES_SBOX_PIPE_FWD_EN: when undefined only the inverse table
// is used and i_inv is ignored.
module aes_sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] i_byte,
  input  logic                  i_inv,
  output logic [AES_BYTE_W-1:0] o_byte_c
);

`ifdef AES_SBOX_PIPE_FWD_EN
  assign o_byte_c = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);
`else
  // Inverse-only build: direction select has no effect.
  logic w_unused_inv;
  assign w_unused_inv = i_inv;
  assign o_byte_c     = sbox_inv(i_byte);
`endif

endmodule

// File: rtl/aes_sbox_pipe.sv
// Two-stage pipelined AES S-box engine with valid/ready on both sides.
//   clk, reset_n                  : clock, async active-low reset
//   in_valid/in_ready             : input handshake (in_ready is combinational)
//   in_word/in_inv/in_tag         : bytes, direction (1 = inverse), sideband tag
//   out_valid/out_ready           : output handshake
//   out_word/out_tag              : substituted bytes and their tag
//   busy                          : a word is in flight
// Build option AES_SBOX_PIPE_FWD_EN: defined = per-transfer direction select;
// undefined = inverse-only, in_inv ignored.
module aes_sbox_pipe
  import aes_sbox_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [AES_BYTE_W*LANES-1:0] in_word,
  input  logic                        in_inv,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AES_BYTE_W*LANES-1:0] out_word,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        busy
);

  localparam int unsigned WORD_W = AES_BYTE_W * LANES;

  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_word;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s2_valid;
  logic [WORD_W-1:0] r_s2_word;
  logic [TAG_W-1:0]  r_s2_tag;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_s1_inv;
  logic [WORD_W-1:0] w_sub_word;

  // Each stage moves when it is empty or the stage after it is moving.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign out_valid = r_s2_valid;
  assign out_word  = r_s2_word;
  assign out_tag   = r_s2_tag;
  assign busy      = r_s1_valid || r_s2_valid;

`ifdef AES_SBOX_PIPE_FWD_EN
  logic r_s1_inv;

  // Direction flag travels with the word in s1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_inv <= 1'b0;
    end else if (w_s1_adv && in_valid) begin
      r_s1_inv <= in_inv;
    end
  end

  assign w_s1_inv = r_s1_inv;
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
  assign w_s1_inv     = 1'b1;
`endif

  // Capture stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_tag   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_word <= in_word;
        r_s1_tag  <= in_tag;
      end
    end
  end

  // Per-lane lookup between s1 and s2.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    aes_sbox_lane u_lane (
      .i_byte   (r_s1_word[gi*AES_BYTE_W +: AES_BYTE_W]),
      .i_inv    (w_s1_inv),
      .o_byte_c (w_sub_word[gi*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  // Output stage; data only reloads on a real word so it holds after a drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
      r_s2_tag   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_word <= w_sub_word;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

endmodule
